// File: rtl/alu_rv_pkg.sv
// -----------------------------------------------------------------------------
// alu_rv_pkg
// Shared constants for the alu_rv execution-unit group.
//   OP_LUI / OP_AUIPC        : 1-bit op select driven by decode into the unit.
//   OPCODE_LUI / OPCODE_AUIPC: major opcodes decode matches to pick the op.
//   U_IMM_SHIFT              : position of the U-type immediate in the word.
//   u_imm32()                : builds the signed 32-bit upper value.
// -----------------------------------------------------------------------------
package alu_rv_pkg;

    localparam logic       OP_LUI       = 1'b0;
    localparam logic       OP_AUIPC     = 1'b1;

    localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;

    localparam int         U_IMM_SHIFT  = 12;

    // Returned as signed so that a width cast to XLEN sign-extends from bit 31.
    function automatic logic signed [31:0] u_imm32(input logic [19:0] imm20);
        return {imm20, {U_IMM_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/alu_upper_immediate_if.sv
// -----------------------------------------------------------------------------
// alu_upper_immediate_if
// Decode-side and writeback-side handshake bundle of the upper-immediate unit.
//   in_valid/in_ready + in_op, in_imm20, in_pc, in_rd : operation request
//   out_valid/out_ready + out_value, out_rd, out_we    : result to writeback
// Modports: master = producer/consumer side (decode + writeback), slave = unit.
// -----------------------------------------------------------------------------
interface alu_upper_immediate_if #(
    parameter int XLEN = 32
) ();

    logic            in_valid;
    logic            in_ready;
    logic            in_op;
    logic [19:0]     in_imm20;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rd;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_value;
    logic [4:0]      out_rd;
    logic            out_we;

    modport master (
        output in_valid, in_op, in_imm20, in_pc, in_rd, out_ready,
        input  in_ready, out_valid, out_value, out_rd, out_we
    );

    modport slave (
        input  in_valid, in_op, in_imm20, in_pc, in_rd, out_ready,
        output in_ready, out_valid, out_value, out_rd, out_we
    );

endinterface

// File: rtl/alu_pipe_stage.sv
// -----------------------------------------------------------------------------
// alu_pipe_stage
// One valid/ready register slice with synchronous flush.
//   clk, rst_n (async low), flush
//   up_valid/up_ready/up_data : upstream side
//   dn_valid/dn_ready/dn_data : downstream side
// The slice takes new data whenever it is empty or its content is leaving,
// so a chain of these runs at one transfer per cycle with no bubbles.
// -----------------------------------------------------------------------------
module alu_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    logic         vld;
    logic [W-1:0] data;

    assign up_ready = !vld || dn_ready;
    assign dn_valid = vld;
    assign dn_data  = data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        vld <= 1'b0;
        else if (flush)    vld <= 1'b0;
        else if (up_ready) vld <= up_valid;
    end

    // Data only moves on a real transfer; it holds (and stays non-X) otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               data <= '0;
        else if (up_valid && up_ready && !flush)  data <= up_data;
    end

endmodule

// File: rtl/alu_upper_immediate.sv
// -----------------------------------------------------------------------------
// alu_upper_immediate
// LUI / AUIPC execution unit with a LATENCY-deep, fully backpressured pipe.
//   XLEN    : 32 or 64
//   LATENCY : 1..3 register stages between accept and result
// Ports:
//   clk, rst_n (async low), flush (kills everything in flight)
//   bus (slave modport): request handshake in, result handshake out
//   perf_lui_cnt / perf_auipc_cnt : retired-op counters, only when
//                                   ALU_UPPER_IMM_PERF_EN is defined
// The result is formed combinationally at the input and then only carried;
// out_we is cleared for rd == x0 so writeback never needs to recheck it.
// -----------------------------------------------------------------------------
module alu_upper_immediate
    import alu_rv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    alu_upper_immediate_if.slave bus
`ifdef ALU_UPPER_IMM_PERF_EN
    ,
    output logic [31:0]          perf_lui_cnt,
    output logic [31:0]          perf_auipc_cnt
`endif
);

`ifdef ALU_UPPER_IMM_PERF_EN
    // Op bit rides along so the counters can classify retired results.
    localparam int PW = XLEN + 7;
`else
    localparam int PW = XLEN + 6;
`endif

    logic [XLEN-1:0]          upper_val;
    logic [XLEN-1:0]          result;
    logic                     rd_we;

    logic [LATENCY:0]         vld_pipe;
    logic                     rdy_pipe [LATENCY+1];
    logic [LATENCY:0][PW-1:0] dat_pipe;

    assign upper_val = XLEN'(u_imm32(bus.in_imm20));
    assign result    = (bus.in_op == OP_AUIPC) ? bus.in_pc + upper_val : upper_val;
    assign rd_we     = (bus.in_rd != 5'd0);

    // Nothing enters during a flush cycle.
    assign vld_pipe[0]       = bus.in_valid && !flush;
    assign bus.in_ready      = !flush && rdy_pipe[0];
    assign rdy_pipe[LATENCY] = bus.out_ready;

`ifdef ALU_UPPER_IMM_PERF_EN
    logic out_op;
    assign dat_pipe[0] = {bus.in_op, rd_we, bus.in_rd, result};
    assign {out_op, bus.out_we, bus.out_rd, bus.out_value} = dat_pipe[LATENCY];
`else
    assign dat_pipe[0] = {rd_we, bus.in_rd, result};
    assign {bus.out_we, bus.out_rd, bus.out_value} = dat_pipe[LATENCY];
`endif

    assign bus.out_valid = vld_pipe[LATENCY];

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        alu_pipe_stage #(.W(PW)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (vld_pipe[g]),
            .up_ready (rdy_pipe[g]),
            .up_data  (dat_pipe[g]),
            .dn_valid (vld_pipe[g+1]),
            .dn_ready (rdy_pipe[g+1]),
            .dn_data  (dat_pipe[g+1])
        );
    end

`ifdef ALU_UPPER_IMM_PERF_EN
    // Counts output handshakes only; a handshake in a flush cycle still counts.
    logic out_fire;
    assign out_fire = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lui_cnt   <= '0;
            perf_auipc_cnt <= '0;
        end else if (out_fire) begin
            if (out_op == OP_AUIPC) begin
                if (perf_auipc_cnt != '1) perf_auipc_cnt <= perf_auipc_cnt + 32'd1;
            end else begin
                if (perf_lui_cnt != '1)   perf_lui_cnt   <= perf_lui_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_upper_immediate.sv
// -----------------------------------------------------------------------------
// tb_alu_upper_immediate
// Directed vectors for two builds of the unit: XLEN=32/LATENCY=3 (u_dut_a)
// and XLEN=64/LATENCY=1 (u_dut_b). Inputs change and outputs are sampled
// around the falling edge. Perf counter checks are present when
// ALU_UPPER_IMM_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_upper_immediate;
    import alu_rv_pkg::*;

    localparam int LAT_A = 3;

    logic clk;
    logic rst_n;
    logic flush_a;
    logic flush_b;

    int n_vec;
    int n_err;

    alu_upper_immediate_if #(.XLEN(32)) ia ();
    alu_upper_immediate_if #(.XLEN(64)) ib ();

`ifdef ALU_UPPER_IMM_PERF_EN
    logic [31:0] perf_lui_a, perf_auipc_a, perf_lui_b, perf_auipc_b;
`endif

    alu_upper_immediate #(.XLEN(32), .LATENCY(LAT_A)) u_dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush_a),
        .bus            (ia.slave)
`ifdef ALU_UPPER_IMM_PERF_EN
        ,
        .perf_lui_cnt   (perf_lui_a),
        .perf_auipc_cnt (perf_auipc_a)
`endif
    );

    alu_upper_immediate #(.XLEN(64), .LATENCY(1)) u_dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush_b),
        .bus            (ib.slave)
`ifdef ALU_UPPER_IMM_PERF_EN
        ,
        .perf_lui_cnt   (perf_lui_b),
        .perf_auipc_cnt (perf_auipc_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One op through u_dut_a with out_ready high; checks latency and result.
    task automatic op_a(input logic op, input logic [19:0] imm, input logic [31:0] pc,
                        input logic [4:0] rd, input logic [31:0] exp_val, input string tag);
        @(negedge clk);
        ia.out_ready = 1'b1;
        ia.in_valid  = 1'b1;
        ia.in_op     = op;
        ia.in_imm20  = imm;
        ia.in_pc     = pc;
        ia.in_rd     = rd;
        @(negedge clk);
        // Scramble operands: only the accept-cycle values may matter.
        ia.in_valid  = 1'b0;
        ia.in_imm20  = 20'($urandom);
        ia.in_pc     = $urandom;
        ia.in_rd     = 5'($urandom);
        repeat (LAT_A - 2) @(negedge clk);
        chk({tag, ".early"}, ia.out_valid, 1'b0);
        @(negedge clk);
        chk({tag, ".vld"}, ia.out_valid, 1'b1);
        chk({tag, ".val"}, ia.out_value, exp_val);
        chk({tag, ".rd"},  ia.out_rd, rd);
        chk({tag, ".we"},  ia.out_we, (rd != 5'd0));
    endtask

    // One op through u_dut_b (latency 1).
    task automatic op_b(input logic op, input logic [19:0] imm, input logic [63:0] pc,
                        input logic [4:0] rd, input logic [63:0] exp_val, input string tag);
        @(negedge clk);
        ib.out_ready = 1'b1;
        ib.in_valid  = 1'b1;
        ib.in_op     = op;
        ib.in_imm20  = imm;
        ib.in_pc     = pc;
        ib.in_rd     = rd;
        #1 chk({tag, ".rdy"}, ib.in_ready, 1'b1);
        @(negedge clk);
        ib.in_valid  = 1'b0;
        ib.in_imm20  = 20'($urandom);
        chk({tag, ".vld"}, ib.out_valid, 1'b1);
        chk({tag, ".val"}, ib.out_value, exp_val);
        chk({tag, ".we"},  ib.out_we, (rd != 5'd0));
    endtask

    initial begin
        int acc, nout, first_out, last_out, seen;
        bit fill_seen;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        flush_a = 1'b0;
        flush_b = 1'b0;
        ia.in_valid = 1'b0; ia.in_op = 1'b0; ia.in_imm20 = '0; ia.in_pc = '0;
        ia.in_rd = '0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_op = 1'b0; ib.in_imm20 = '0; ib.in_pc = '0;
        ib.in_rd = '0; ib.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.vld",   ia.out_valid, 1'b0);
        chk("rst.val",   ia.out_value, 32'h0);
        chk("rst.rd",    ia.out_rd, 5'd0);
        chk("rst.we",    ia.out_we, 1'b0);
        chk("rst.vld_b", ib.out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.rdy",   ia.in_ready, 1'b1);

        // Basic function, XLEN=32 LATENCY=3
        op_a(OP_LUI,   20'h12345, 32'hDEAD_BEEF, 5'd5,  32'h1234_5000, "lui");
        op_a(OP_AUIPC, 20'h00002, 32'hFFFF_F000, 5'd7,  32'h0000_1000, "auipc_wrap");
        op_a(OP_LUI,   20'hABCDE, 32'h0000_0000, 5'd0,  32'hABCD_E000, "lui_x0");
        op_a(OP_AUIPC, 20'hFFFFF, 32'h0001_0000, 5'd31, 32'h0000_F000, "auipc_neg");

        // XLEN=64 LATENCY=1: sign extension and 64-bit wrap
        op_b(OP_AUIPC, 20'h80000, 64'h1000,                 5'd3,  64'hFFFF_FFFF_8000_1000, "b.auipc");
        op_b(OP_LUI,   20'h7FFFF, 64'hFFFF_FFFF_FFFF_FFFF,  5'd31, 64'h0000_0000_7FFF_F000, "b.lui");
        op_b(OP_AUIPC, 20'h00001, 64'hFFFF_FFFF_FFFF_F000,  5'd0,  64'h0,                   "b.wrap");

        // Backpressure: ops 1..8 back to back, out_ready low for 5 cycles
        acc = 0; nout = 0; first_out = -1; last_out = -1; fill_seen = 1'b0;
        for (int c = 0; c < 40 && nout < 8; c++) begin
            @(negedge clk);
            ia.out_ready = (c >= 5);
            ia.in_valid  = (acc < 8);
            ia.in_op     = OP_LUI;
            ia.in_imm20  = 20'(acc + 1);
            ia.in_rd     = 5'(acc + 1);
            #1;
            if (ia.out_valid && ia.out_ready) begin
                chk("bp.val", ia.out_value, 32'(nout + 1) << 12);
                chk("bp.rd",  ia.out_rd, 5'(nout + 1));
                if (first_out < 0) first_out = c;
                last_out = c;
                nout++;
            end
            if (c == 4) chk("bp.hold", ia.out_value, 32'h1000);
            if (ia.in_valid && !ia.in_ready && !fill_seen) begin
                fill_seen = 1'b1;
                chk("bp.fill", acc, 3);
            end
            if (ia.in_valid && ia.in_ready) acc++;
        end
        ia.in_valid = 1'b0;
        chk("bp.fill_seen", fill_seen, 1'b1);
        chk("bp.count", nout, 8);
        chk("bp.first", first_out, 5);
        chk("bp.rate",  last_out - first_out, 7);

        // Flush with two ops in flight and a third offered
        @(negedge clk);
        ia.out_ready = 1'b1;
        ia.in_valid = 1'b1; ia.in_op = OP_LUI; ia.in_imm20 = 20'h11; ia.in_rd = 5'd1;
        @(negedge clk);
        ia.in_imm20 = 20'h22; ia.in_rd = 5'd2;
        @(negedge clk);
        flush_a = 1'b1;
        ia.in_imm20 = 20'h33; ia.in_rd = 5'd3;
        #1 chk("fl.rdy", ia.in_ready, 1'b0);
        @(negedge clk);
        flush_a = 1'b0;
        ia.in_valid = 1'b0;
        chk("fl.vld", ia.out_valid, 1'b0);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (ia.out_valid) seen++;
        end
        chk("fl.quiet", seen, 0);
        op_a(OP_AUIPC, 20'h00044, 32'h0000_0100, 5'd4, 32'h0004_4100, "fl.next");

`ifdef ALU_UPPER_IMM_PERF_EN
        // Counters from a clean reset: 3 LUI + 2 AUIPC retired, 1 AUIPC flushed
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        op_a(OP_LUI,   20'h00001, 32'h0,    5'd1, 32'h0000_1000, "pf.l1");
        op_a(OP_AUIPC, 20'h00001, 32'h10,   5'd2, 32'h0000_1010, "pf.a1");
        op_a(OP_LUI,   20'h00002, 32'h0,    5'd3, 32'h0000_2000, "pf.l2");
        op_a(OP_AUIPC, 20'h00002, 32'h20,   5'd4, 32'h0000_2020, "pf.a2");
        op_a(OP_LUI,   20'h00003, 32'h0,    5'd5, 32'h0000_3000, "pf.l3");
        @(negedge clk);
        ia.in_valid = 1'b1; ia.in_op = OP_AUIPC; ia.in_imm20 = 20'h9; ia.in_rd = 5'd9;
        @(negedge clk);
        ia.in_valid = 1'b0;
        flush_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("pf.lui",   perf_lui_a, 32'd3);
        chk("pf.auipc", perf_auipc_a, 32'd2);
`endif

        // Reset asserted while a result sits stalled at the output
        @(negedge clk);
        ia.out_ready = 1'b0;
        ia.in_valid = 1'b1; ia.in_op = OP_LUI; ia.in_imm20 = 20'h55; ia.in_rd = 5'd5;
        @(negedge clk);
        ia.in_valid = 1'b0;
        repeat (LAT_A - 1) @(negedge clk);
        chk("mr.pre", ia.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr.vld", ia.out_valid, 1'b0);
        chk("mr.val", ia.out_value, 32'h0);
`ifdef ALU_UPPER_IMM_PERF_EN
        chk("mr.lui",   perf_lui_a, 32'd0);
        chk("mr.auipc", perf_auipc_a, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr.rdy", ia.in_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
